// File: rtl/mem_multiport_clr.sv
// mem_multiport_clr: byte-writable RAM with one read/write port, NUM_RD read ports and a full-array clear sweep
module mem_multiport_clr #(
  parameter int ADR_WIDTH  = 10,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD     = 2,
  parameter int REG_READ   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [DATA_WIDTH/8-1:0]          be,
  input  logic [ADR_WIDTH-1:0]             adr1,
  input  logic [DATA_WIDTH-1:0]            data1w,
  output logic [DATA_WIDTH-1:0]            data1r,
  input  logic [NUM_RD*ADR_WIDTH-1:0]      rd_adr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
  input  logic                             clr_req,
  output logic                             busy
);
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, nxt;
  logic [ADR_WIDTH-1:0] clr_ptr, nxt_ptr;
  logic [DATA_WIDTH-1:0] mem [2**ADR_WIDTH];
  logic [DATA_WIDTH-1:0] wmask;
  assign busy = state == CLEAR;
  // sweep ends on the edge that clears the last word; clr_req only matters in IDLE
  always_comb begin
    nxt = state == IDLE ? (clr_req ? CLEAR : IDLE) : (&clr_ptr ? IDLE : CLEAR);
    nxt_ptr = state == CLEAR ? clr_ptr + 1'b1 : '0;
  end
  // state register; reset restarts the sweep from word 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= nxt;
      clr_ptr <= nxt_ptr;
    end
  // expand byte strobes to a bit mask for write-first forwarding
  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++) wmask[i*8 +: 8] = {8{be[i]}};
  end
  // storage: the sweep owns the array while busy, otherwise byte-masked port-1 writes
  always_ff @(posedge clk)
    if (busy) mem[clr_ptr] <= '0;
    else if (we)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[adr1][i*8 +: 8] <= data1w[i*8 +: 8];
  for (genvar p = 0; p <= NUM_RD; p++) begin : g_port
    logic [ADR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] q;
    if (p == 0) begin : g_p1
      assign a = adr1;
      assign data1r = busy ? '0 : q;
    end else begin : g_rd
      assign a = rd_adr[(p-1)*ADR_WIDTH +: ADR_WIDTH];
      assign rd_data[(p-1)*DATA_WIDTH +: DATA_WIDTH] = busy ? '0 : q;
    end
    if (REG_READ != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] nw;
      assign nw = busy ? (a == clr_ptr ? '0 : mem[a]) :
                  (we && a == adr1) ? (mem[a] & ~wmask) | (data1w & wmask) : mem[a];
      // registered read captures the word as it will be after this edge
      always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else q <= nw;
    end else begin : g_comb
      assign q = mem[a];
    end
  end
endmodule

// File: tb/tb_mem_multiport_clr.sv
// tb_mem_multiport_clr: random and directed checks of both read modes against an array model
module tb_mem_multiport_clr;
  localparam int AW = 4, DW = 64, NR = 3;
  logic clk = 0, rst = 1, we = 0, clr_req = 0;
  logic [DW/8-1:0] be = '0;
  logic [AW-1:0] adr1 = '0;
  logic [DW-1:0] data1w = '0;
  logic [NR*AW-1:0] rd_adr = '0;
  logic [DW-1:0] a_d1r, r_d1r;
  logic [NR*DW-1:0] a_rd, r_rd;
  logic a_busy, r_busy;
  int checks = 0, errors = 0;
  logic [DW-1:0] m [16];
  logic [DW-1:0] q [NR+1];
  logic mbusy = 1;
  int cnt = 0;

  always #5 clk = ~clk;

  mem_multiport_clr #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .REG_READ(0)) dut_a (
    .clk(clk), .rst(rst), .we(we), .be(be), .adr1(adr1), .data1w(data1w), .data1r(a_d1r),
    .rd_adr(rd_adr), .rd_data(a_rd), .clr_req(clr_req), .busy(a_busy));
  mem_multiport_clr #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .REG_READ(1)) dut_r (
    .clk(clk), .rst(rst), .we(we), .be(be), .adr1(adr1), .data1w(data1w), .data1r(r_d1r),
    .rd_adr(rd_adr), .rd_data(r_rd), .clr_req(clr_req), .busy(r_busy));

  function automatic logic [AW-1:0] padr(int p);
    return p == 0 ? adr1 : rd_adr[(p-1)*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] aout(int p);
    return p == 0 ? a_d1r : a_rd[(p-1)*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] rout(int p);
    return p == 0 ? r_d1r : r_rd[(p-1)*DW +: DW];
  endfunction

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare();
    chk("async_busy", 64'(a_busy), 64'(mbusy));
    chk("reg_busy", 64'(r_busy), 64'(mbusy));
    for (int p = 0; p <= NR; p++) begin
      chk($sformatf("async_p%0d_adr%0d", p, padr(p)), aout(p), mbusy ? '0 : m[padr(p)]);
      chk($sformatf("reg_p%0d", p), rout(p), mbusy ? '0 : q[p]);
    end
  endtask

  task automatic zero_q();
    for (int p = 0; p <= NR; p++) q[p] = '0;
  endtask

  // one rising edge: advance the model using the inputs seen at the edge, then check
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mbusy = 1;
      cnt = 0;
      m[0] = '0;
      zero_q();
    end else begin
      if (mbusy) begin
        m[cnt] = '0;
        cnt++;
        if (cnt == 16) begin
          mbusy = 0;
          cnt = 0;
        end
      end else begin
        if (we)
          for (int i = 0; i < DW/8; i++)
            if (be[i]) m[adr1][i*8 +: 8] = data1w[i*8 +: 8];
        if (clr_req) begin
          mbusy = 1;
          cnt = 0;
        end
      end
      for (int p = 0; p <= NR; p++) q[p] = m[padr(p)];
    end
    #1;
    compare();
  endtask

  task automatic sweep_len(string tag, int exp);
    int n = 0;
    while (a_busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp));
  endtask

  task automatic set_all(logic [AW-1:0] a);
    adr1 = a;
    rd_adr = {a, a, a};
  endtask

  task automatic read_all();
    for (int w = 0; w < 16; w++) begin
      set_all(4'(w));
      tick();
    end
  endtask

  task automatic write(logic [AW-1:0] a, logic [DW-1:0] d, logic [7:0] b);
    we = 1;
    adr1 = a;
    data1w = d;
    be = b;
    tick();
    we = 0;
  endtask

  initial begin
    for (int w = 0; w < 16; w++) m[w] = '0;
    zero_q();
    tick();
    tick();
    rst = 0;
    sweep_len("init_sweep", 16);
    read_all();

    write(4'd3, 64'h1122334455667788, 8'hFF);
    write(4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    set_all(4'd3);
    tick();
    chk("merge_async", a_d1r, 64'h11223344AAAAAAAA);
    chk("merge_reg", r_rd[DW-1:0], 64'h11223344AAAAAAAA);

    write(4'd5, 64'h1234, 8'hFF);
    we = 1;
    adr1 = 4'd5;
    data1w = 64'hDEAD;
    be = 8'hFF;
    rd_adr = {4'd0, 4'd0, 4'd5};
    #1;
    chk("pre_edge_async", a_rd[DW-1:0], 64'h1234);
    tick();
    we = 0;
    chk("post_edge_async", a_rd[DW-1:0], 64'hDEAD);
    chk("wfirst_reg", r_rd[DW-1:0], 64'hDEAD);

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      be = 8'($urandom);
      adr1 = 4'($urandom);
      data1w = {$urandom, $urandom};
      rd_adr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) rd_adr[AW-1:0] = adr1;
      clr_req = $urandom_range(0, 60) == 0;
      tick();
    end
    clr_req = 0;
    we = 0;
    sweep_len("rand_tail", a_busy ? cnt == 0 ? 16 : 16 - cnt : 0);

    for (int w = 0; w < 16; w++) write(4'(w), {$urandom, $urandom} | 64'h1, 8'hFF);
    clr_req = 1;
    tick();
    chk("clr_busy", 64'(a_busy), 64'h1);
    we = 1;
    adr1 = 4'd2;
    data1w = '1;
    be = 8'hFF;
    set_all(4'd2);
    for (int n = 0; n < 3; n++) tick();
    clr_req = 0;
    we = 0;
    sweep_len("clr_sweep", 13);
    read_all();
    set_all(4'd2);
    tick();
    chk("clr_adr2", a_d1r, '0);

    write(4'd7, 64'h77, 8'hFF);
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int n = 0; n < 7; n++) tick();
    rst = 1;
    #1;
    mbusy = 1;
    cnt = 0;
    zero_q();
    compare();
    tick();
    rst = 0;
    sweep_len("rst_sweep", 16);
    read_all();

    write(4'd9, 64'h55, 8'hFF);
    set_all(4'd9);
    tick();
    for (int p = 0; p <= NR; p++) begin
      chk($sformatf("same_async_p%0d", p), aout(p), 64'h55);
      chk($sformatf("same_reg_p%0d", p), rout(p), 64'h55);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
